landing_gear_sensor_conditioner: RTL and testbench
==================================================

LANDING_GEAR_SENSOR_CONDITIONER -- requirements
Module: landing_gear_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized raw input must differ from its debounced output before that output changes; legal range 1..255.
REQ-002 Parameter TIMEUP_CYCLES, default 2000: counting cycles from Timer release to TimeUp (2 s at the 1 ms clock); legal range 1..65535.
REQ-003 Clock  input  1  system clock; all flops on its rising edge.
REQ-004 ClearN  input  1  reset, asynchronous, active-low.
REQ-005 RawGearUp  input  1  gear-up limit switch, asynchronous, may bounce.
REQ-006 RawGearDown  input  1  gear-down limit switch, asynchronous, may bounce.
REQ-007 RawOnGround  input  1  weight-on-wheels switch, asynchronous, may bounce.
REQ-008 Timer  input  1  from landing gear controller; 1 = reset timer, 0 = count.
REQ-009 GearIsUp  output  1  debounced, conflict-masked gear-up indication.
REQ-010 GearIsDown  output  1  debounced, conflict-masked gear-down indication.
REQ-011 PlaneOnGround  output  1  debounced weight-on-wheels indication.
REQ-012 TimeUp  output  1  takeoff interval elapsed.
REQ-013 SensorFault  output  1  gear up and down both asserted after debounce.

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Each channel SHALL keep a debounce counter that clears whenever synchronized value equals debounced value and increments otherwise.
REQ-016 A debounced value SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then clears.
REQ-017 Latency from a clean raw edge to the debounced change SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-018 The takeoff counter SHALL clear while Timer = 1 and SHALL increment each cycle Timer = 0, saturating at TIMEUP_CYCLES.
REQ-019 TimeUp SHALL be 1 exactly when the takeoff counter equals TIMEUP_CYCLES, i.e. after TIMEUP_CYCLES edges with Timer = 0.
REQ-020 Timer = 1 SHALL take priority; TimeUp SHALL fall on the first edge at which Timer = 1 is sampled and stay 0 while it remains 1.
REQ-021 TimeUp SHALL stay 1 while Timer stays 0 after saturation; no wrap-around.
REQ-022 Conflict FSM states: OK, CONFLICT, LATCHED; conflict = debounced up AND debounced down.
REQ-023 OK -> CONFLICT on conflict; CONFLICT -> OK when conflict clears (non-latching build); CONFLICT -> LATCHED on the next edge (latching build); LATCHED exits only on reset.
REQ-024 SensorFault SHALL be 1 in CONFLICT and LATCHED, 0 in OK; it is registered, asserting one edge after the conflict appears on the debounced values.
REQ-025 While SensorFault = 1, GearIsUp and GearIsDown SHALL both be driven 0; otherwise they equal the debounced values.
REQ-026 PlaneOnGround SHALL never be masked by the conflict FSM.
REQ-027 All outputs SHALL be glitch-free register outputs or a single AND of register outputs.

Reset
REQ-028 ClearN low SHALL immediately force: synchronizer and debounced up = 0, down = 1, on-ground = 1; all counters 0; FSM = OK.
REQ-029 Resulting output values: GearIsUp 0, GearIsDown 1, PlaneOnGround 1, TimeUp 0, SensorFault 0.
REQ-030 Reset asserted mid-debounce or mid-count SHALL discard partial progress; deassertion SHALL be synchronized internally so the first active edge is clean.

Configuration
REQ-031 Macro GEAR_FAULT_LATCH_EN defined: LATCHED state present; SensorFault and masking persist until ClearN.
REQ-032 Macro GEAR_FAULT_LATCH_EN undefined: LATCHED state absent; SensorFault follows conflict per REQ-023/REQ-024.

Verification
REQ-033 Reset, hold raw inputs at reset values 20 cycles -> outputs 0,1,1,0,0 throughout.
REQ-034 DEBOUNCE_CYCLES=4, RawOnGround 1->0 clean -> PlaneOnGround falls exactly 6 edges later; 3-cycle pulse to 0 -> no change.
REQ-035 TIMEUP_CYCLES=2000, Timer 1->0 -> TimeUp rises after 2000 edges; Timer=1 at cycle 1500 then 0 -> rises 2000 edges after release; Timer=1 after rise -> falls next edge.
REQ-036 RawGearDown kept 1, RawGearUp driven 1 -> one edge after debounced conflict SensorFault=1, GearIsUp=GearIsDown=0.
REQ-037 Conflict then RawGearDown 0: with GEAR_FAULT_LATCH_EN SensorFault stays 1 until ClearN pulse; without it SensorFault clears one edge after debounced down falls and GearIsUp=1.
REQ-038 ClearN pulsed low during debounce at count 3 and takeoff count 1000 -> all counters 0, outputs at reset values, no change from the aborted progress.

Source files
------------

// File: rtl/landing_gear_sensor_conditioner_if.sv
// rtl/landing_gear_sensor_conditioner_if.sv - raw sensor inputs and conditioned indications of the gear sensor conditioner
interface landing_gear_sensor_conditioner_if;
    logic RawGearUp;
    logic RawGearDown;
    logic RawOnGround;
    logic Timer;
    logic GearIsUp;
    logic GearIsDown;
    logic PlaneOnGround;
    logic TimeUp;
    logic SensorFault;

    modport master (
        output RawGearUp, RawGearDown, RawOnGround, Timer,
        input  GearIsUp, GearIsDown, PlaneOnGround, TimeUp, SensorFault
    );

    modport slave (
        input  RawGearUp, RawGearDown, RawOnGround, Timer,
        output GearIsUp, GearIsDown, PlaneOnGround, TimeUp, SensorFault
    );
endinterface

// File: rtl/landing_gear_sensor_conditioner.sv
// rtl/landing_gear_sensor_conditioner.sv - sync/debounce of gear switches, takeoff timer, gear conflict FSM
// Optional macro GEAR_FAULT_LATCH_EN makes a gear conflict latch until ClearN.
module landing_gear_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEUP_CYCLES   = 2000
) (
    input  logic Clock,
    input  logic ClearN,
    landing_gear_sensor_conditioner_if.slave sif
);
    // Channel order: bit0 gear up, bit1 gear down, bit2 on ground.
    localparam logic [2:0]  RST_VAL  = 3'b110;
    localparam logic [7:0]  CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] T_MAX    = 16'(TIMEUP_CYCLES);

`ifdef GEAR_FAULT_LATCH_EN
    typedef enum logic [1:0] {ST_OK, ST_CONFLICT, ST_LATCHED} state_t;
`else
    typedef enum logic [1:0] {ST_OK, ST_CONFLICT} state_t;
`endif

    logic            rst_meta_q, rst_sync_q;
    logic [2:0]      raw;
    logic [2:0]      meta_q, sync_q;
    logic [2:0]      deb_q, deb_d;
    logic [2:0][7:0] cnt_q, cnt_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            time_up_q, time_up_d;
    logic            conflict;
    state_t          state_q;
    logic            fault_q;

    // Assert immediately, release two edges later so the first active edge is clean.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign raw = {sif.RawOnGround, sif.RawGearDown, sif.RawGearUp};

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (sif.Timer) begin
            tcnt_d = '0;
        end else if (tcnt_q != T_MAX) begin
            tcnt_d = tcnt_q + 16'd1;
        end
        time_up_d = (tcnt_d == T_MAX);
    end

    always_ff @(posedge Clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            meta_q    <= RST_VAL;
            sync_q    <= RST_VAL;
            deb_q     <= RST_VAL;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            time_up_q <= 1'b0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            time_up_q <= time_up_d;
        end
    end

    assign conflict = deb_q[0] & deb_q[1];

    always_ff @(posedge Clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_OK;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (conflict) begin
                        state_q <= ST_CONFLICT;
                        fault_q <= 1'b1;
                    end
                end
`ifdef GEAR_FAULT_LATCH_EN
                ST_CONFLICT: begin
                    state_q <= ST_LATCHED;
                    fault_q <= 1'b1;
                end
                ST_LATCHED: begin
                    state_q <= ST_LATCHED;
                    fault_q <= 1'b1;
                end
`else
                ST_CONFLICT: begin
                    if (!conflict) begin
                        state_q <= ST_OK;
                        fault_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_OK;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign sif.GearIsUp      = deb_q[0] & ~fault_q;
    assign sif.GearIsDown    = deb_q[1] & ~fault_q;
    assign sif.PlaneOnGround = deb_q[2];
    assign sif.TimeUp        = time_up_q;
    assign sif.SensorFault   = fault_q;
endmodule

// File: tb/tb_landing_gear_sensor_conditioner.sv
// tb/tb_landing_gear_sensor_conditioner.sv - randomized scoreboard bench for landing_gear_sensor_conditioner
module tb_landing_gear_sensor_conditioner;
    localparam int DEB = 4;
    localparam int TUP = 2000;
`ifdef GEAR_FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif
    localparam logic [2:0] RV = 3'b110;

    logic clk;
    logic clear_n;
    landing_gear_sensor_conditioner_if sif();

    landing_gear_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEUP_CYCLES  (TUP)
    ) dut (
        .Clock (clk),
        .ClearN(clear_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done    = 1'b0;
    bit started = 1'b0;
    logic [4:0] exp_q[$];

    // Reference model: a channel switches once its last DEB synchronized samples
    // all disagree with it; the sample seen at an edge is the raw value two edges back.
    logic [2:0] m_deb;
    logic [7:0] m_win [3];
    logic [1:0] m_rawh[3];
    int         m_run;
    bit         m_fault;
    int         m_rel;

    task automatic model_reset();
        m_deb   = RV;
        for (int c = 0; c < 3; c++) begin
            m_win[c]  = {8{RV[c]}};
            m_rawh[c] = {2{RV[c]}};
        end
        m_run   = 0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] raw, input logic timer, input logic cn);
        logic [7:0] mask;
        logic [7:0] want;
        logic       s;
        mask = 8'((1 << DEB) - 1);
        if (!cn) begin
            model_reset();
            m_rel = 0;
        end else if (m_rel < 2) begin
            m_rel++;
            model_reset();
        end else begin
            m_fault = LATCH ? (m_fault | (m_deb[0] & m_deb[1])) : (m_deb[0] & m_deb[1]);
            if (timer) m_run = 0;
            else if (m_run < TUP) m_run++;
            for (int c = 0; c < 3; c++) begin
                s = m_rawh[c][1];
                m_rawh[c] = {m_rawh[c][0], raw[c]};
                m_win[c] = {m_win[c][6:0], s};
                want = m_deb[c] ? 8'h00 : 8'hFF;
                if ((m_win[c] & mask) == (want & mask)) m_deb[c] = ~m_deb[c];
            end
        end
    endtask

    initial begin
        model_reset();
        m_rel = 0;
        while (!done) begin
            @(posedge clk);
            model_edge({sif.RawOnGround, sif.RawGearDown, sif.RawGearUp}, sif.Timer, clear_n);
            #3;
            if (!clear_n) begin
                model_reset();
                m_rel = 0;
            end
            exp_q.push_back({m_deb[0] & ~m_fault, m_deb[1] & ~m_fault, m_deb[2],
                             m_run == TUP, m_fault});
            started = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [4:0] got;
        logic [4:0] want;
        if (started && !done) begin
            got = {sif.GearIsUp, sif.GearIsDown, sif.PlaneOnGround, sif.TimeUp, sif.SensorFault};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty @%0t: got %b, no expected entry", $time, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL outputs{up,down,gnd,timeup,fault} @%0t: got %b expected %b",
                             $time, got, want);
                end
            end
        end
    end

    logic [2:0] lvl;
    int         gl[3];
    int         timer_hold;
    int         rst_hold;

    task automatic drive_raw();
        logic [2:0] v;
        for (int c = 0; c < 3; c++) begin
            if (gl[c] > 0) begin
                gl[c]--;
                v[c] = ~lvl[c];
            end else begin
                if ($urandom_range(0, 59) == 0) lvl[c] = ~lvl[c];
                else if ($urandom_range(0, 79) == 0) gl[c] = $urandom_range(1, 5);
                v[c] = (gl[c] > 0) ? ~lvl[c] : lvl[c];
            end
        end
        sif.RawGearUp   = v[0];
        sif.RawGearDown = v[1];
        sif.RawOnGround = v[2];
    endtask

    initial begin
        clear_n         = 1'b0;
        lvl             = RV;
        gl[0] = 0; gl[1] = 0; gl[2] = 0;
        timer_hold      = 0;
        rst_hold        = 0;
        sif.RawGearUp   = 1'b0;
        sif.RawGearDown = 1'b1;
        sif.RawOnGround = 1'b1;
        sif.Timer       = 1'b1;
        repeat (3) @(posedge clk);
        #2 clear_n = 1'b1;
        repeat (25) @(posedge clk);
        #2 sif.Timer = 1'b0;
        repeat (2100) @(posedge clk);
        #2 sif.Timer = 1'b1;
        @(posedge clk);
        #2 sif.Timer = 1'b0;
        for (int n = 0; n < 26000; n++) begin
            @(posedge clk);
            #2;
            drive_raw();
            if (timer_hold > 0) begin
                timer_hold--;
                sif.Timer = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                timer_hold = $urandom_range(0, 3);
                sif.Timer  = 1'b1;
            end else begin
                sif.Timer = 1'b0;
            end
            if (rst_hold > 0) begin
                rst_hold--;
                clear_n = 1'b0;
            end else if ($urandom_range(0, 4999) == 0) begin
                rst_hold = $urandom_range(0, 2);
                clear_n  = 1'b0;
            end else begin
                clear_n = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        done = 1'b1;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
